// File: rtl/eth_rx_mac_filter_pkg.sv
// Shared Ethernet definitions for the receive MAC address filter: FSM states,
// address constants, statistics counter indices and the accept rule.
package eth_rx_mac_filter_pkg;

    localparam int          ETH_ALEN       = 6;
    localparam logic [47:0] ETH_BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

    localparam int STAT_PASS     = 0;
    localparam int STAT_ADDR     = 1;
    localparam int STAT_RUNT     = 2;
    localparam int STAT_OVERRUN  = 3;
    localparam int STAT_NUM      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_PASS  = 3'd2,
        ST_DROP  = 3'd3,
        ST_FLUSH = 3'd4
    } rx_state_e;

    // Destination-address acceptance; da[40] is the I/G bit of the first byte on the wire.
    function automatic logic mac_accept(
        input logic [47:0] da,
        input logic [47:0] mac,
        input logic        promisc,
        input logic        bcast_en,
        input logic        mcast_en
    );
        logic is_bcast;
        is_bcast = (da == ETH_BCAST_ADDR);
        return promisc || (da == mac) || (bcast_en && is_bcast) ||
               (mcast_en && da[40] && !is_bcast);
    endfunction

endpackage

// File: rtl/eth_rx_mac_filter_if.sv
// Byte stream bundle (AXI-Stream style without back-pressure) used on both
// sides of the receive MAC filter.
interface eth_rx_mac_filter_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, tvalid, tlast, tuser);
    modport slave  (input  tdata, tvalid, tlast, tuser);

endinterface

// File: rtl/eth_rx_mac_filter_sat_counter.sv
// Saturating up-counter for frame statistics; sticks at all-ones.
module eth_rx_mac_filter_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/eth_rx_mac_filter.sv
// Receive-side destination MAC filter: buffers the 6-byte DA, decides pass/drop,
// then forwards the frame through the buffer with a fixed 6-beat delay.
module eth_rx_mac_filter
    import eth_rx_mac_filter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_rx_mac_filter_if.slave    s_axis,
    eth_rx_mac_filter_if.master   m_axis,
    input  logic [47:0]           local_mac_i,
    input  logic                  cfg_promisc_i,
    input  logic                  cfg_accept_bcast_i,
    input  logic                  cfg_accept_mcast_i,
    output logic [CNT_WIDTH-1:0]  stat_pass_o,
    output logic [CNT_WIDTH-1:0]  stat_drop_addr_o,
    output logic [CNT_WIDTH-1:0]  stat_drop_runt_o,
    output logic [CNT_WIDTH-1:0]  stat_drop_overrun_o,
    output logic                  drop_pulse_o
);

    if (DATA_WIDTH != 8) begin : g_width_check
        $error("eth_rx_mac_filter: DATA_WIDTH must be 8");
    end

    localparam logic [2:0] LAST_HDR_IDX = 3'(ETH_ALEN - 1);
    localparam logic [2:0] FLUSH_LEN    = 3'(ETH_ALEN);

    rx_state_e                    state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [ETH_ALEN-1:0][7:0]     hdr_q, hdr_d;
    logic [47:0]                  mac_q, mac_d;
    logic                         promisc_q, promisc_d;
    logic                         bcast_q, bcast_d;
    logic                         mcast_q, mcast_d;
    logic                         tuser_q, tuser_d;
    logic                         ovr_q, ovr_d;
    logic                         ovr_next;
    logic                         out_valid_q, out_valid_d;
    logic [7:0]                   out_data_q, out_data_d;
    logic                         out_last_q, out_last_d;
    logic                         out_user_q, out_user_d;
    logic                         drop_pulse_q, drop_pulse_d;
    logic [47:0]                  da;
    logic [STAT_NUM-1:0]          stat_inc;
    logic [CNT_WIDTH-1:0]         stat_val [STAT_NUM];

    // Five buffered bytes plus the byte on the bus form the complete DA.
    assign da = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], s_axis.tdata};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        mac_d        = mac_q;
        promisc_d    = promisc_q;
        bcast_d      = bcast_q;
        mcast_d      = mcast_q;
        tuser_d      = tuser_q;
        ovr_d        = ovr_q;
        ovr_next     = ovr_q;
        out_valid_d  = 1'b0;
        out_data_d   = hdr_q[0];
        out_last_d   = 1'b0;
        out_user_d   = 1'b0;
        stat_inc     = '0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis.tvalid) begin
                    hdr_d[0]  = s_axis.tdata;
                    cnt_d     = 3'd1;
                    mac_d     = local_mac_i;
                    promisc_d = cfg_promisc_i;
                    bcast_d   = cfg_accept_bcast_i;
                    mcast_d   = cfg_accept_mcast_i;
                    if (s_axis.tlast) begin
                        stat_inc[STAT_RUNT] = 1'b1;
                        cnt_d               = 3'd0;
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end

            ST_HDR: begin
                if (s_axis.tvalid) begin
                    if (s_axis.tlast) begin
                        stat_inc[STAT_RUNT] = 1'b1;
                        cnt_d               = 3'd0;
                        state_d             = ST_IDLE;
                    end else begin
                        hdr_d[cnt_q] = s_axis.tdata;
                        cnt_d        = cnt_q + 3'd1;
                        if (cnt_q == LAST_HDR_IDX) begin
                            if (mac_accept(da, mac_q, promisc_q, bcast_q, mcast_q)) begin
                                state_d = ST_PASS;
                            end else begin
                                stat_inc[STAT_ADDR] = 1'b1;
                                state_d             = ST_DROP;
                            end
                        end
                    end
                end
            end

            ST_PASS: begin
                if (s_axis.tvalid) begin
                    out_valid_d = 1'b1;
                    hdr_d       = {s_axis.tdata, hdr_q[ETH_ALEN-1:1]};
                    if (s_axis.tlast) begin
                        tuser_d = s_axis.tuser;
                        ovr_d   = 1'b0;
                        cnt_d   = FLUSH_LEN;
                        state_d = ST_FLUSH;
                    end
                end
            end

            ST_FLUSH: begin
                out_valid_d = 1'b1;
                hdr_d       = {8'h00, hdr_q[ETH_ALEN-1:1]};
                cnt_d       = cnt_q - 3'd1;
                // A beat seen while flushing belongs to a frame we have no room for.
                if (s_axis.tvalid) begin
                    if (!ovr_q) begin
                        stat_inc[STAT_OVERRUN] = 1'b1;
                    end
                    ovr_next = !s_axis.tlast;
                end
                ovr_d = ovr_next;
                if (cnt_q == 3'd1) begin
                    out_last_d          = 1'b1;
                    out_user_d          = tuser_q;
                    stat_inc[STAT_PASS] = 1'b1;
                    cnt_d               = 3'd0;
                    ovr_d               = 1'b0;
                    state_d             = ovr_next ? ST_DROP : ST_IDLE;
                end
            end

            ST_DROP: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    cnt_d   = 3'd0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = 3'd0;
                state_d = ST_IDLE;
            end
        endcase

        drop_pulse_d = stat_inc[STAT_ADDR] | stat_inc[STAT_RUNT] | stat_inc[STAT_OVERRUN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hdr_q        <= '0;
            mac_q        <= '0;
            promisc_q    <= 1'b0;
            bcast_q      <= 1'b0;
            mcast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            ovr_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hdr_q        <= hdr_d;
            mac_q        <= mac_d;
            promisc_q    <= promisc_d;
            bcast_q      <= bcast_d;
            mcast_q      <= mcast_d;
            tuser_q      <= tuser_d;
            ovr_q        <= ovr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_user_q   <= out_user_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    for (genvar gi = 0; gi < STAT_NUM; gi++) begin : g_stat
        eth_rx_mac_filter_sat_counter #(
            .WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_i   (stat_inc[gi]),
            .count_o (stat_val[gi])
        );
    end

    assign m_axis.tdata        = out_data_q;
    assign m_axis.tvalid       = out_valid_q;
    assign m_axis.tlast        = out_last_q;
    assign m_axis.tuser        = out_user_q;
    assign drop_pulse_o        = drop_pulse_q;
    assign stat_pass_o         = stat_val[STAT_PASS];
    assign stat_drop_addr_o    = stat_val[STAT_ADDR];
    assign stat_drop_runt_o    = stat_val[STAT_RUNT];
    assign stat_drop_overrun_o = stat_val[STAT_OVERRUN];

endmodule

// File: doc/eth_rx_mac_filter.md
ETH_RX_MAC_FILTER -- requirements
Module: eth_rx_mac_filter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, byte-wide stream width; any other value SHALL fail elaboration.
REQ-002 Parameter CNT_WIDTH, default 32, width of the statistics counters.
REQ-003 clk  in  1  clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 s_axis_tdata/tvalid/tlast/tuser  in  8/1/1/1  frame bytes from the GMII receiver; no tready; tuser=1 on tlast marks bad frame.
REQ-006 m_axis_tdata/tvalid/tlast/tuser  out  8/1/1/1  filtered frames; no tready.
REQ-007 local_mac  in  48  station address; byte 0 (first on wire) = bits [47:40].
REQ-008 cfg_promisc, cfg_accept_bcast, cfg_accept_mcast  in  1 each  filter enables.
REQ-009 stat_pass, stat_drop_addr, stat_drop_runt, stat_drop_overrun  out  CNT_WIDTH each  saturating frame counters.
REQ-010 drop_pulse  out  1  one-cycle pulse per dropped frame.

Function
REQ-011 Block SHALL hold a 6-entry byte buffer (data only) and states IDLE, HDR, PASS, DROP, FLUSH.
REQ-012 IDLE: first valid beat SHALL be stored, count=1, go HDR; cfg inputs and local_mac SHALL be sampled on this beat and held for the frame.
REQ-013 HDR: valid beats SHALL be appended; on the 6th byte the decision SHALL be made combinationally from the 6 buffered bytes.
REQ-014 Accept = promisc OR DA==local_mac OR (cfg_accept_bcast AND DA==FF:FF:FF:FF:FF:FF) OR (cfg_accept_mcast AND DA byte0 bit0=1 AND not broadcast); accept -> PASS, else -> DROP.
REQ-015 tlast in IDLE or HDR (frame <=6 bytes) SHALL drop the frame, increment stat_drop_runt, return IDLE, emit nothing.
REQ-016 PASS: each valid non-last input beat SHALL shift in and emit the oldest buffered byte with m_axis_tvalid=1 the next cycle (latency 1 cycle, 6 beats).
REQ-017 PASS, valid tlast beat: emit oldest byte, enter FLUSH, then emit remaining 6 bytes on 6 consecutive cycles; final byte SHALL carry tlast=1 and tuser=input tuser of the last beat.
REQ-018 stat_pass SHALL increment when the final flushed byte is emitted, regardless of tuser.
REQ-019 DROP: beats SHALL be discarded until tlast, then IDLE; stat_drop_addr increments and drop_pulse asserts on the decision cycle.
REQ-020 Valid beat arriving during FLUSH SHALL be discarded, its frame treated as DROP (remaining beats discarded to tlast), stat_drop_overrun incremented; flush SHALL complete unaffected.
REQ-021 Overrun beat that is itself tlast SHALL increment stat_drop_overrun and leave next state IDLE after flush.
REQ-022 m_axis_tvalid SHALL be 0 in all cycles other than REQ-016/017 emissions; tdata/tlast/tuser are don't-care when tvalid=0 but tlast/tuser SHALL be 0 on non-final beats.
REQ-023 Counters SHALL saturate at all-ones; simultaneous increments of different counters SHALL all take effect.
REQ-024 Output frames SHALL be byte-identical to input frames (DA included), never interleaved or truncated.

Reset
REQ-025 rst SHALL set state IDLE, buffer count 0, m_axis_tvalid/tlast/tuser=0, drop_pulse=0, all counters 0.
REQ-026 rst mid-frame SHALL abandon the frame without emitting tlast; following beats without a new frame start are treated as a new frame.

Structure
REQ-027 State encoding, ETH_ALEN=6 and broadcast constant SHALL live in the shared Ethernet package.
REQ-028 One sub-module natural: sat_counter (parameter width, inc input), instantiated four times.

Verification
REQ-029 60-byte frame, DA=local_mac=02:00:00:00:00:01 -> identical 60 bytes out, tlast on byte 60, tuser=0, stat_pass=1.
REQ-030 Frame DA=FF:FF:FF:FF:FF:FF, cfg_accept_bcast=0, promisc=0 -> no output, stat_drop_addr=1, one drop_pulse; set cfg_accept_bcast=1 -> passes.
REQ-031 5-byte frame -> no output, stat_drop_runt=1; 7-byte matching frame -> 7 bytes out, 6 flush cycles after tlast.
REQ-032 Matching frame with tuser=1 on tlast -> full frame out, tuser=1 on last byte only, stat_pass=1.
REQ-033 New frame beat 2 cycles after tlast of passing frame -> first frame intact, second dropped, stat_drop_overrun=1.
REQ-034 rst asserted at byte 20 of passing frame -> tvalid=0 next cycle, counters 0; next full frame passes normally.
